// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared FSM states, HD44780 opcodes and geometry for the LCD bus receiver.
package lcd_bus_pkg;
  typedef enum logic [1:0] {S_INIT8, S_HI, S_LO, S_CLR} state_e;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME = 8'h02;
  localparam logic [7:0] ENTRY = 8'h04;
  localparam logic [7:0] FUNC = 8'h20;
  localparam logic [7:0] SET_DDRAM = 8'h80;
  localparam logic [7:0] LINE2_BASE = 8'h40;
  localparam logic [7:0] SPACE = 8'h20;
  localparam int CHARS_PER_LINE = 16;
  function automatic logic [6:0] ddram_addr(input logic [4:0] c);
    return (int'(c) >= CHARS_PER_LINE ? LINE2_BASE[6:0] : 7'h00) | {3'b000, c[3:0]};
  endfunction
endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: multi-flop synchronizer for the LCD bus inputs plus falling-edge detect of E.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic       e_i,
  input  logic [3:0] data_i,
  output logic       rs_o,
  output logic       rw_o,
  output logic       e_o,
  output logic [3:0] data_o,
  output logic       fall_o
);
  logic [6:0] sync_q [SYNC_STAGES];
  logic       e_prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {rs_i, rw_i, e_i, data_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev_q <= e_o;
    end
  end
  assign {rs_o, rw_o, e_o, data_o} = sync_q[SYNC_STAGES-1];
  assign fall_o = e_prev_q & ~e_o;
endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: HD44780 4-bit bus responder with 32-char shadow buffer and cursor.
// Define LCD_RX_READBACK_EN to answer RW=1 cycles with busy flag and DDRAM address.
module lcd_bus_receiver
  import lcd_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CHARS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [3:0] lcd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic [4:0] cursor_addr,
  output logic       busy,
  output logic       err_overrun,
  input  logic [4:0] buf_rd_addr,
  output logic [7:0] buf_rd_char,
  output logic [3:0] bus_dout,
  output logic       bus_oe
);
  logic       s_rs, s_rw, s_e, ev;
  logic [3:0] s_data;
  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .rs_i(lcd_rs), .rw_i(lcd_rw), .e_i(lcd_e), .data_i(lcd_data),
    .rs_o(s_rs), .rw_o(s_rw), .e_o(s_e), .data_o(s_data), .fall_o(ev)
  );
  state_e     state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic [4:0] cursor_q, cursor_d, clr_cnt_q, clr_cnt_d;
  logic       dir_q, dir_d, valid_q, valid_d, is_data_q, is_data_d, overrun_q, overrun_d;
  logic [7:0] byte_q, byte_d;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem [CHARS];
  logic       wr_ev, rd_ev, accept;
  logic [7:0] byte_w;
  assign wr_ev = ev & ~s_rw;
`ifdef LCD_RX_READBACK_EN
  assign rd_ev = ev & s_rw;
`else
  assign rd_ev = 1'b0;
`endif
  assign byte_w = {hi_q, s_data};
  assign accept = wr_ev && state_q == S_LO;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT8;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT8: if (wr_ev && s_data == 4'h2) state_d = S_HI;
      S_HI:    if (wr_ev || rd_ev) state_d = S_LO;
      S_LO: begin
        if (rd_ev) state_d = S_HI;
        else if (wr_ev)
          state_d = (!s_rs && byte_w == CLEAR) ? S_CLR :
                    (!s_rs && (byte_w & 8'hE0) == FUNC && byte_w[4]) ? S_INIT8 : S_HI;
      end
      S_CLR:   if (clr_cnt_q == 5'd31) state_d = S_HI;
      default: state_d = S_INIT8;
    endcase
  end
  // Datapath: byte capture, command side effects and the single buffer write port.
  always_comb begin
    hi_d = (wr_ev && state_q == S_HI) ? s_data : hi_q;
    cursor_d = cursor_q;
    dir_d = dir_q;
    clr_cnt_d = clr_cnt_q;
    valid_d = accept;
    byte_d = accept ? byte_w : byte_q;
    is_data_d = accept ? s_rs : is_data_q;
    overrun_d = overrun_q | (wr_ev && state_q == S_CLR);
    mem_we = 1'b0;
    mem_waddr = cursor_q;
    mem_wdata = byte_w;
    if (accept && s_rs) begin
      mem_we = 1'b1;
      cursor_d = dir_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
    end
    if (accept && !s_rs) begin
      if ((byte_w & SET_DDRAM) != 8'h00)
        cursor_d = byte_w[6:4] == 3'b000 ? {1'b0, byte_w[3:0]} :
                   byte_w[6:4] == LINE2_BASE[6:4] ? {1'b1, byte_w[3:0]} : cursor_q;
      else if ((byte_w & 8'hFC) == ENTRY) dir_d = byte_w[1];
      else if ((byte_w & 8'hFE) == HOME) cursor_d = 5'd0;
      else if (byte_w == CLEAR) begin
        cursor_d = 5'd0;
        dir_d = 1'b1;
        clr_cnt_d = 5'd0;
      end
    end
    if (state_q == S_CLR) begin
      mem_we = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = SPACE;
      clr_cnt_d = clr_cnt_q + 5'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      cursor_q <= '0;
      clr_cnt_q <= '0;
      dir_q <= 1'b1;
      valid_q <= 1'b0;
      byte_q <= '0;
      is_data_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      cursor_q <= cursor_d;
      clr_cnt_q <= clr_cnt_d;
      dir_q <= dir_d;
      valid_q <= valid_d;
      byte_q <= byte_d;
      is_data_q <= is_data_d;
      overrun_q <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_rd_char <= '0;
    else buf_rd_char <= mem[buf_rd_addr];
  end
  always_comb begin
    busy = state_q == S_CLR;
`ifdef LCD_RX_READBACK_EN
    bus_oe = s_e & s_rw;
    bus_dout = state_q == S_LO ? ddram_addr(cursor_q)[3:0] : {busy, 1'b0, ddram_addr(cursor_q)[5:4]};
`else
    bus_oe = 1'b0;
    bus_dout = 4'h0;
`endif
  end
`ifndef LCD_RX_READBACK_EN
  logic unused_e;
  assign unused_e = s_e;
`endif
  assign byte_valid = valid_q;
  assign byte_data = byte_q;
  assign byte_is_data = is_data_q;
  assign cursor_addr = cursor_q;
  assign err_overrun = overrun_q;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: randomized bus traffic checked against a behavioural display model.
module tb_lcd_bus_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [3:0] lcd_data = 4'h0;
  logic [4:0] buf_rd_addr = 5'd0;
  logic byte_valid, byte_is_data, busy, err_overrun, bus_oe;
  logic [7:0] byte_data, buf_rd_char;
  logic [4:0] cursor_addr;
  logic [3:0] bus_dout;
  int checks = 0, errors = 0;
  int vcount = 0, busy_cyc = 0;
  int m_cur = 0, m_dir = 1, m_valid = 0;
  logic [7:0] m_buf [32];

  lcd_bus_receiver dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .cursor_addr(cursor_addr), .busy(busy), .err_overrun(err_overrun),
    .buf_rd_addr(buf_rd_addr), .buf_rd_char(buf_rd_char), .bus_dout(bus_dout), .bus_oe(bus_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) vcount <= vcount + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic model_byte(input logic rs, input logic [7:0] b);
    int a;
    m_valid++;
    if (rs) begin
      m_buf[m_cur] = b;
      m_cur = (m_cur + (m_dir == 1 ? 1 : 31)) % 32;
    end else if (b >= 8'h80) begin
      a = int'(b) - 128;
      if (a < 16) m_cur = a;
      else if (a >= 64 && a < 80) m_cur = a - 64 + 16;
    end else if (b >= 8'h04 && b < 8'h08) m_dir = b[1] ? 1 : 0;
    else if (b == 8'h02 || b == 8'h03) m_cur = 0;
    else if (b == 8'h01) begin
      m_cur = 0; m_dir = 1;
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    end
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    nib(rs, 1'b0, b[7:4]);
    nib(rs, 1'b0, b[3:0]);
    model_byte(rs, b);
  endtask

  task automatic read_buf(input int a, output logic [7:0] d);
    @(negedge clk) buf_rd_addr = 5'(a);
    @(negedge clk) d = buf_rd_char;
  endtask

  task automatic check_all_buf(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 32; i++) begin
      read_buf(i, d);
      checks++;
      if (d !== m_buf[i]) begin
        errors++;
        $display("FAIL %s buf[%0d]: got %h want %h", tag, i, d, m_buf[i]);
      end
    end
  endtask

  task automatic check_state(input string tag);
    checks++;
    if (cursor_addr !== 5'(m_cur)) begin
      errors++;
      $display("FAIL %s cursor: got %0d want %0d", tag, cursor_addr, m_cur);
    end
    checks++;
    if (vcount !== m_valid) begin
      errors++;
      $display("FAIL %s byte_valid count: got %0d want %0d", tag, vcount, m_valid);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_valid, byte_data, byte_is_data, cursor_addr, busy, err_overrun, buf_rd_char, bus_dout, bus_oe} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b want all zero",
               {byte_valid, byte_data, byte_is_data, cursor_addr, busy, err_overrun, buf_rd_char, bus_dout, bus_oe});
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
  endtask

  task automatic test_init;
    nib(1'b0, 1'b0, 4'h3); nib(1'b0, 1'b0, 4'h3); nib(1'b0, 1'b0, 4'h3); nib(1'b0, 1'b0, 4'h2);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL init nibbles: got %0d bytes want 0", vcount);
    end
    send_byte(1'b0, 8'h28);
    check_state("init");
    checks++;
    if (byte_data !== 8'h28 || byte_is_data !== 1'b0) begin
      errors++;
      $display("FAIL init byte: got %h/%b want 28/0", byte_data, byte_is_data);
    end
  endtask

  task automatic test_clear;
    int b0, v0, n;
    b0 = busy_cyc;
    send_byte(1'b0, 8'h01);
    v0 = vcount;
    nib(1'b1, 1'b0, 4'h7); nib(1'b1, 1'b0, 4'h7);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL clear timeout: busy still %b want 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy_cyc - b0 !== 32) begin
      errors++;
      $display("FAIL clear busy length: got %0d want 32", busy_cyc - b0);
    end
    checks++;
    if (vcount !== v0 || err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL clear drop: got bytes %0d overrun %b want %0d 1", vcount, err_overrun, v0);
    end
    check_state("clear");
    check_all_buf("clear");
  endtask

  task automatic test_hi;
    send_byte(1'b1, 8'h48);
    send_byte(1'b1, 8'h69);
    check_state("hi");
    send_byte(1'b0, 8'hC5);
    send_byte(1'b1, 8'h41);
    check_state("ddram");
    checks++;
    if (byte_is_data !== 1'b1 || byte_data !== 8'h41) begin
      errors++;
      $display("FAIL ddram byte: got %h/%b want 41/1", byte_data, byte_is_data);
    end
    check_all_buf("hi");
  endtask

  task automatic test_wrap;
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h04);
    send_byte(1'b1, 8'h58);
    check_state("wrap");
    send_byte(1'b0, 8'h06);
    check_all_buf("wrap");
  endtask

  task automatic test_random;
    logic rs;
    logic [7:0] b;
    int r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      rs = r < 6;
      if (r < 6) b = 8'($urandom_range(0, 255));
      else if (r < 8)
        b = 8'h80 | 8'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 127) :
                        $urandom_range(0, 1) * 64 + $urandom_range(0, 15));
      else b = 8'h04 | 8'($urandom_range(0, 3));
      send_byte(rs, b);
      check_state("random");
      checks++;
      if (byte_data !== b || byte_is_data !== rs) begin
        errors++;
        $display("FAIL random byte: got %h/%b want %h/%b", byte_data, byte_is_data, b, rs);
      end
    end
    check_all_buf("random");
  endtask

  task automatic test_func_init;
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'h33);
    nib(1'b0, 1'b0, 4'h5); nib(1'b0, 1'b0, 4'h3); nib(1'b0, 1'b0, 4'h2);
    send_byte(1'b1, 8'h5A);
    check_state("func");
    check_all_buf("func");
  endtask

`ifdef LCD_RX_READBACK_EN
  task automatic test_readback;
    int dd;
    logic [3:0] exp;
    send_byte(1'b0, 8'hC1);
    dd = (m_cur / 16) * 64 + (m_cur % 16);
    for (int p = 0; p < 2; p++) begin
      exp = p == 0 ? 4'((dd / 16) % 4) : 4'(dd % 16);
      @(negedge clk);
      lcd_rw = 1'b1; lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (bus_oe !== 1'b1 || bus_dout !== exp) begin
        errors++;
        $display("FAIL readback nibble %0d: got oe %b dout %h want 1 %h", p, bus_oe, bus_dout, exp);
      end
      lcd_e = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus_oe !== 1'b0) begin
        errors++;
        $display("FAIL readback oe low: got %b want 0", bus_oe);
      end
    end
    lcd_rw = 1'b0;
    send_byte(1'b1, 8'h62);
    check_state("readback");
    check_all_buf("readback");
  endtask
`else
  task automatic test_rw_ignored;
    @(negedge clk);
    lcd_rw = 1'b1; lcd_data = 4'h9; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_oe !== 1'b0 || bus_dout !== 4'h0) begin
      errors++;
      $display("FAIL rw idle bus: got oe %b dout %h want 0 0", bus_oe, bus_dout);
    end
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
    send_byte(1'b1, 8'h7A);
    check_state("rw");
    check_all_buf("rw");
  endtask
`endif

  initial begin
    test_reset;
    test_init;
    test_clear;
    test_hi;
    test_wrap;
    test_random;
    test_func_init;
`ifdef LCD_RX_READBACK_EN
    test_readback;
`else
    test_rw_ignored;
`endif
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL sticky overrun: got %b want 1", err_overrun);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
